// File: rtl/fft16_out_serializer.sv
// Captures one frame of parallel FFT results on the rising edge of done and streams it bin by bin.
// Build option FFT_SER_PINGPONG_EN adds a shadow buffer so a frame arriving mid-stream is kept.
module fft16_out_serializer #(
  parameter int unsigned  N      = 16,
  parameter int unsigned  DATA_W = 12,
  parameter int unsigned  GAIN_W = 4,
  localparam int unsigned OUT_W  = DATA_W + GAIN_W,
  localparam int unsigned IDX_W  = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fft_done,
  input  logic                    fft_mode,
  input  logic signed [OUT_W-1:0] fft_real_in [N],
  input  logic signed [OUT_W-1:0] fft_imag_in [N],
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_real,
  output logic signed [OUT_W-1:0] m_imag,
  output logic [IDX_W-1:0]        m_index,
  output logic                    m_last,
  output logic                    m_mode,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  state_e                  state;
  logic                    done_d;
  logic signed [OUT_W-1:0] act_re [N];
  logic signed [OUT_W-1:0] act_im [N];
  logic                    pend;
  logic                    cap;
  logic                    xfer;
  logic                    final_xfer;
  logic                    load_new;
  logic                    load_sh;
  logic                    drop;
  logic [IDX_W-1:0]        idx_next;

`ifdef FFT_SER_PINGPONG_EN
  logic signed [OUT_W-1:0] sh_re [N];
  logic signed [OUT_W-1:0] sh_im [N];
  logic                    sh_mode;
  logic                    pend_q;
  logic                    sh_load;

  assign pend = pend_q;
`else
  assign pend = 1'b0;
`endif

  always_comb begin
    cap        = fft_done & ~done_d;
    xfer       = (state == StStream) & m_valid & m_ready;
    final_xfer = xfer & m_last;
    // The final transfer frees the active buffer, so a cap on that cycle is always taken.
    load_sh    = final_xfer & pend;
    load_new   = cap & ((state == StIdle) | (final_xfer & ~pend));
    idx_next   = m_index + 1'b1;
`ifdef FFT_SER_PINGPONG_EN
    sh_load    = cap & (state == StStream) & (final_xfer ? pend : ~pend);
    drop       = cap & (state == StStream) & ~final_xfer & pend;
`else
    drop       = cap & (state == StStream) & ~final_xfer;
`endif
  end

  assign busy = (state == StStream) | pend;

  // Control FSM with registered beat outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= StIdle;
      done_d  <= 1'b0;
      m_valid <= 1'b0;
      m_real  <= '0;
      m_imag  <= '0;
      m_index <= '0;
      m_last  <= 1'b0;
      m_mode  <= 1'b0;
      overrun <= 1'b0;
`ifdef FFT_SER_PINGPONG_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      done_d  <= fft_done;
      overrun <= drop | (overrun & ~clr_overrun);
      if (load_new) begin
        state   <= StStream;
        m_valid <= 1'b1;
        m_real  <= fft_real_in[0];
        m_imag  <= fft_imag_in[0];
        m_index <= '0;
        m_last  <= (LastIdx == '0);
        m_mode  <= fft_mode;
`ifdef FFT_SER_PINGPONG_EN
      end else if (load_sh) begin
        m_valid <= 1'b1;
        m_real  <= sh_re[0];
        m_imag  <= sh_im[0];
        m_index <= '0;
        m_last  <= (LastIdx == '0);
        m_mode  <= sh_mode;
`endif
      end else if (final_xfer) begin
        state   <= StIdle;
        m_valid <= 1'b0;
        m_index <= '0;
        m_last  <= 1'b0;
      end else if (xfer) begin
        m_real  <= act_re[idx_next];
        m_imag  <= act_im[idx_next];
        m_index <= idx_next;
        m_last  <= (idx_next == LastIdx);
      end
`ifdef FFT_SER_PINGPONG_EN
      if (load_sh) begin
        pend_q <= sh_load;
      end else if (sh_load) begin
        pend_q <= 1'b1;
      end
`endif
    end
  end

  // Frame storage; contents are only meaningful while the FSM says a frame is held.
  always_ff @(posedge clk) begin
    if (rst_n && load_new) begin
      act_re <= fft_real_in;
      act_im <= fft_imag_in;
    end
`ifdef FFT_SER_PINGPONG_EN
    else if (rst_n && load_sh) begin
      act_re <= sh_re;
      act_im <= sh_im;
    end
    if (rst_n && sh_load) begin
      sh_re   <= fft_real_in;
      sh_im   <= fft_imag_in;
      sh_mode <= fft_mode;
    end
`endif
  end

endmodule

// File: tb/tb_fft16_out_serializer.sv
// Directed bench for fft16_out_serializer; expectations adapt to FFT_SER_PINGPONG_EN.
module tb_fft16_out_serializer;

  localparam int N     = 16;
  localparam int OUT_W = 16;
  localparam int IDX_W = 4;
  localparam int MaxB  = 512;

  logic                    clk = 1'b0;
  logic                    rst_n, fft_done, fft_mode, m_ready, clr_overrun;
  logic signed [OUT_W-1:0] real_in [N];
  logic signed [OUT_W-1:0] imag_in [N];
  logic                    m_valid, m_last, m_mode, busy, overrun;
  logic signed [OUT_W-1:0] m_real, m_imag;
  logic [IDX_W-1:0]        m_index;

  fft16_out_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fft_done   (fft_done),
    .fft_mode   (fft_mode),
    .fft_real_in(real_in),
    .fft_imag_in(imag_in),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_real     (m_real),
    .m_imag     (m_imag),
    .m_index    (m_index),
    .m_last     (m_last),
    .m_mode     (m_mode),
    .busy       (busy),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int nbeats  = 0;
  int base    = 0;
  int b_re [MaxB];
  int b_im [MaxB];
  int b_idx [MaxB];
  int b_last [MaxB];
  int b_mode [MaxB];
  int b_cyc [MaxB];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Beat recorder plus hold-while-stalled check.
  logic stall_prev = 1'b0;
  int   sv_re, sv_im, sv_idx, sv_mode;
  always @(negedge clk) begin
    if (rst_n && stall_prev) begin
      check("stall_valid", int'(m_valid), 1);
      check("stall_re", int'(m_real), sv_re);
      check("stall_im", int'(m_imag), sv_im);
      check("stall_idx", int'(m_index), sv_idx);
      check("stall_mode", int'(m_mode), sv_mode);
    end
    if (rst_n && m_valid && m_ready && nbeats < MaxB) begin
      b_re[nbeats]   = int'(m_real);
      b_im[nbeats]   = int'(m_imag);
      b_idx[nbeats]  = int'(m_index);
      b_last[nbeats] = int'(m_last);
      b_mode[nbeats] = int'(m_mode);
      b_cyc[nbeats]  = cyc;
      nbeats++;
    end
    stall_prev = rst_n && m_valid && !m_ready;
    sv_re      = int'(m_real);
    sv_im      = int'(m_imag);
    sv_idx     = int'(m_index);
    sv_mode    = int'(m_mode);
  end

  function automatic int exp_re(input int kind, input int k);
    case (kind)
      0:       return k;
      1:       return 100 + k;
      2:       return (k == 0) ? 32767 : ((k == 15) ? -1 : k);
      3:       return 1000 + 7 * k;
      default: return -2000 - k;
    endcase
  endfunction

  function automatic int exp_im(input int kind, input int k);
    case (kind)
      0:       return -k;
      1:       return 200 - 3 * k;
      2:       return (k == 0) ? -32768 : -k;
      3:       return -500 + k;
      default: return 3000 + k;
    endcase
  endfunction

  task automatic set_frame(input int kind, input logic mode);
    for (int k = 0; k < N; k++) begin
      real_in[k] = OUT_W'(exp_re(kind, k));
      imag_in[k] = OUT_W'(exp_im(kind, k));
    end
    fft_mode = mode;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic wait_beats(input string tag, input int n);
    for (int i = 0; i < 200 && (nbeats - base) < n; i++) tick();
    check({tag, "_reach"}, int'((nbeats - base) >= n), 1);
  endtask

  task automatic check_frame(input string tag, input int off, input int kind, input int mode);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_idx%0d", tag, k), b_idx[base+off+k], k);
      check($sformatf("%s_re%0d", tag, k), b_re[base+off+k], exp_re(kind, k));
      check($sformatf("%s_im%0d", tag, k), b_im[base+off+k], exp_im(kind, k));
      check($sformatf("%s_last%0d", tag, k), b_last[base+off+k], int'(k == N - 1));
      check($sformatf("%s_mode%0d", tag, k), b_mode[base+off+k], mode);
    end
  endtask

  task automatic clear_overrun();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("clr_overrun", int'(overrun), 0);
  endtask

  initial begin
    int nlast;
    rst_n = 1'b0; fft_done = 1'b0; fft_mode = 1'b0; m_ready = 1'b1; clr_overrun = 1'b0;
    set_frame(0, 1'b0);
    repeat (3) tick();
    check("rst_valid", int'(m_valid), 0);
    check("rst_real", int'(m_real), 0);
    check("rst_index", int'(m_index), 0);
    check("rst_last", int'(m_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    tick();

    // 1: basic frame, one-cycle capture latency, back-to-back beats
    base = nbeats;
    set_frame(0, 1'b0);
    fft_done = 1'b1;
    @(negedge clk);
    check("t1_valid_pre", int'(m_valid), 0);
    tick();
    fft_done = 1'b0;
    check("t1_valid_post", int'(m_valid), 1);
    check("t1_index0", int'(m_index), 0);
    check("t1_busy", int'(busy), 1);
    wait_idle("t1");
    check("t1_count", nbeats - base, 16);
    check_frame("t1", 0, 0, 0);
    check("t1_span", b_cyc[base+15] - b_cyc[base], 15);

    // 2: toggling ready, done held high for 40 cycles
    base = nbeats;
    set_frame(1, 1'b0);
    fork
      begin
        fft_done = 1'b1;
        repeat (40) tick();
        fft_done = 1'b0;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          m_ready = ~m_ready;
          tick();
        end
        m_ready = 1'b1;
      end
    join
    wait_idle("t2");
    check("t2_count", nbeats - base, 16);
    check_frame("t2", 0, 1, 0);
    check("t2_overrun", int'(overrun), 0);

    // 3: extreme values, IFFT mode tag
    base = nbeats;
    set_frame(2, 1'b1);
    pulse_done();
    wait_idle("t3");
    check("t3_count", nbeats - base, 16);
    check("t3_re0", b_re[base], 32767);
    check("t3_im0", b_im[base], -32768);
    check("t3_re15", b_re[base+15], -1);
    check_frame("t3", 0, 2, 1);

    // 4: second done rise mid-frame
    base = nbeats;
    set_frame(3, 1'b0);
    pulse_done();
    wait_beats("t4", 5);
    set_frame(4, 1'b1);
    pulse_done();
    wait_idle("t4");
    check_frame("t4a", 0, 3, 0);
`ifdef FFT_SER_PINGPONG_EN
    check("t4_count", nbeats - base, 32);
    check_frame("t4b", 16, 4, 1);
    check("t4_gap", b_cyc[base+16] - b_cyc[base+15], 1);
    check("t4_overrun", int'(overrun), 0);
`else
    check("t4_count", nbeats - base, 16);
    check("t4_overrun", int'(overrun), 1);
`endif
    clear_overrun();

    // 5: third cap while one is pending, clr_overrun on the dropping cycle
    base = nbeats;
    set_frame(0, 1'b0);
    pulse_done();
    wait_beats("t5a", 3);
    set_frame(1, 1'b1);
    pulse_done();
    wait_beats("t5b", 8);
    set_frame(3, 1'b0);
    clr_overrun = 1'b1;
    pulse_done();
    clr_overrun = 1'b0;
    check("t5_overrun_set_wins", int'(overrun), 1);
    wait_idle("t5");
    check_frame("t5a", 0, 0, 0);
`ifdef FFT_SER_PINGPONG_EN
    check("t5_count", nbeats - base, 32);
    check_frame("t5b", 16, 1, 1);
`else
    check("t5_count", nbeats - base, 16);
`endif
    check("t5_overrun_end", int'(overrun), 1);
    clear_overrun();

    // 6a: cap exactly on A's final transfer
    base = nbeats;
    set_frame(3, 1'b0);
    pulse_done();
    repeat (15) tick();
    check("t6_last_now", int'(m_last), 1);
    set_frame(4, 1'b1);
    pulse_done();
    check("t6_valid", int'(m_valid), 1);
    check("t6_index0", int'(m_index), 0);
    check("t6_mode", int'(m_mode), 1);
    check("t6_overrun", int'(overrun), 0);
    wait_idle("t6");
    check("t6_count", nbeats - base, 32);
    check_frame("t6a", 0, 3, 0);
    check_frame("t6b", 16, 4, 1);
    check("t6_gap", b_cyc[base+16] - b_cyc[base+15], 1);

    // 6b: reset mid-frame
    base = nbeats;
    set_frame(0, 1'b0);
    pulse_done();
    wait_beats("t6r", 7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6r_valid", int'(m_valid), 0);
    check("t6r_last", int'(m_last), 0);
    check("t6r_real", int'(m_real), 0);
    check("t6r_index", int'(m_index), 0);
    check("t6r_busy", int'(busy), 0);
    nlast = 0;
    for (int i = base; i < nbeats; i++) nlast += b_last[i];
    check("t6r_no_last", nlast, 0);
    check("t6r_partial", int'((nbeats - base) < 16), 1);
    tick();
    base = nbeats;
    set_frame(1, 1'b0);
    pulse_done();
    wait_idle("t6c");
    check("t6c_count", nbeats - base, 16);
    check_frame("t6c", 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
